// File: rtl/mem_xfer_pkg.sv
// rtl/mem_xfer_pkg.sv - shared types and helpers for the memory access unit
package mem_xfer_pkg;

    typedef enum logic [1:0] {IDLE, XFER, RESP} mau_state_t;

    typedef logic [1:0] xfer_log2_t;

    localparam xfer_log2_t SZ_B = 2'd0;
    localparam xfer_log2_t SZ_H = 2'd1;
    localparam xfer_log2_t SZ_W = 2'd2;
    localparam xfer_log2_t SZ_D = 2'd3;

    function automatic logic [3:0] size_bytes(input xfer_log2_t sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - sign/zero extension of assembled load data
module load_extend
    import mem_xfer_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [63:0] extended
);

    always_comb begin
        extended = data;
        case (size)
            SZ_B:    extended = {{56{sign_ext & data[7]}},  data[7:0]};
            SZ_H:    extended = {{48{sign_ext & data[15]}}, data[15:0]};
            SZ_W:    extended = {{32{sign_ext & data[31]}}, data[31:0]};
            SZ_D:    extended = data;
            default: extended = data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store requests to data memory beats with bounds check and assembly
module mem_access_unit
    import mem_xfer_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_error,
    output logic [63:0] mem_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [63:0] mem_write_data,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    mau_state_t  state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    xfer_log2_t  size_q, size_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        misal_q, misal_d;
    logic [63:0] asm_q, asm_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_error_q, rsp_error_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_size_q, mem_size_d;

    logic [3:0]  bytes_in;
    logic [3:0]  bytes_q;
    logic [64:0] end_addr;
    logic        oob;
    logic        mis_in;
    logic        last_beat;
    logic [2:0]  beat_nxt;
    logic [63:0] ext_data;

    load_extend u_load_extend (
        .data     (asm_q),
        .size     (size_q),
        .sign_ext (signed_q),
        .extended (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        write_d     = write_q;
        signed_d    = signed_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        misal_d     = misal_q;
        asm_d       = asm_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_error_d = rsp_error_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        mem_wdata_d = mem_wdata_q;
        mem_size_d  = mem_size_q;

        bytes_in  = size_bytes(req_size);
        bytes_q   = size_bytes(size_q);
        // 65-bit sum so an access ending past 2^64 cannot wrap back in bounds
        end_addr  = {1'b0, req_addr} + 65'(bytes_in);
        oob       = end_addr > 65'(MEM_BYTES);
        mis_in    = (req_addr[3:0] & (bytes_in - 4'd1)) != 4'd0;
        last_beat = !misal_q || ({1'b0, beat_q} == (bytes_q - 4'd1));
        beat_nxt  = beat_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    signed_d    = req_signed;
                    size_d      = req_size;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    misal_d     = mis_in;
                    asm_d       = '0;
                    beat_d      = 3'd0;
                    req_ready_d = 1'b0;
                    if (oob) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d     = XFER;
                        mem_addr_d  = req_addr;
                        mem_we_d    = req_write;
                        mem_re_d    = !req_write;
                        mem_size_d  = mis_in ? 4'd1 : bytes_in;
                        mem_wdata_d = mis_in ? {56'b0, req_wdata[7:0]} : req_wdata;
                    end
                end
            end
            XFER: begin
                if (mem_re_q) begin
                    if (misal_q) begin
                        asm_d[{beat_q, 3'b000} +: 8] = mem_read_data[7:0];
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            if (i < int'(bytes_q)) asm_d[8*i +: 8] = mem_read_data[8*i +: 8];
                        end
                    end
                end
                if (last_beat) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b0;
                    mem_addr_d  = '0;
                    mem_we_d    = 1'b0;
                    mem_re_d    = 1'b0;
                    mem_wdata_d = '0;
                    mem_size_d  = 4'd8;
                end else begin
                    beat_d      = beat_nxt;
                    mem_addr_d  = addr_q + {61'b0, beat_nxt};
                    mem_wdata_d = {56'b0, wdata_q[{beat_nxt, 3'b000} +: 8]};
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_error_d = 1'b0;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_error_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_q      <= 3'd0;
            write_q     <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= SZ_D;
            addr_q      <= '0;
            wdata_q     <= '0;
            misal_q     <= 1'b0;
            asm_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_size_q  <= 4'd8;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            write_q     <= write_d;
            signed_q    <= signed_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            misal_q     <= misal_d;
            asm_q       <= asm_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_wdata_q <= mem_wdata_d;
            mem_size_q  <= mem_size_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_error        = rsp_error_q;
    // Data is only meaningful for a successful load, and reads as zero otherwise
    assign rsp_rdata        = (rsp_valid_q && !rsp_error_q && !write_q) ? ext_data : '0;
    assign mem_address      = mem_addr_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;
    assign mem_write_data   = mem_wdata_q;
    assign mem_xfer_size    = mem_size_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural data memory
module tb_mem_access_unit;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_error;
    logic [63:0] mem_address;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [63:0] mem_write_data;
    logic [3:0]  mem_xfer_size;
    logic [63:0] mem_read_data;

    always #2500 clk = ~clk;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_xfer_size    (mem_xfer_size),
        .mem_read_data    (mem_read_data)
    );

    // Attached data memory: combinational little-endian read, write on posedge
    logic [7:0] mem_arr [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem_arr[i] <= 8'(i * 7 + 3);
        end else if (mem_write_enable) begin
            for (int i = 0; i < 8; i++) begin
                if (i < int'(mem_xfer_size) && (mem_address + 64'(i)) < 64'(MEM_BYTES))
                    mem_arr[10'(mem_address + 64'(i))] <= mem_write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++) begin
            if ((mem_address + 64'(i)) < 64'(MEM_BYTES))
                mem_read_data[8*i +: 8] = mem_arr[10'(mem_address + 64'(i))];
        end
    end

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  sz;
        logic        we;
        logic [63:0] wd;
    } beat_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    beat_t bq[$];
    rsp_t  rq[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    en_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    beat_t mb;
    rsp_t  mr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write_enable || mem_read_enable) begin
                en_cnt++;
                if (bq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got beat at %h expected none", mem_address);
                end else begin
                    mb = bq.pop_front();
                    check("beat_addr", mem_address, mb.addr);
                    check("beat_size", 64'(mem_xfer_size), 64'(mb.sz));
                    check("beat_we", 64'(mem_write_enable), 64'(mb.we));
                    check("beat_re", 64'(mem_read_enable), 64'(!mb.we));
                    check("beat_wdata", mem_write_data, mb.wd);
                end
            end
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid expected none");
                end else begin
                    mr = rq.pop_front();
                    check("rsp_rdata", rsp_rdata, mr.rdata);
                    check("rsp_error", 64'(rsp_error), 64'(mr.err));
                    check("rsp_cycle", 64'(cyc), 64'(mr.cyc));
                end
            end
        end
    end

    function automatic logic [63:0] extend(input logic [63:0] v, input int nb, input logic sg);
        logic [63:0] m;
        if (nb == 8) return v;
        m = (64'd1 << (8 * nb)) - 64'd1;
        v = v & m;
        if (sg && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    // Issue at a negedge; pushes expected beats and response from the reference memory
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [63:0] a,
                         input logic [63:0] wd, input int commit, input logic keep, output int acc);
        int          nb;
        int          n;
        logic [64:0] e;
        logic [63:0] v;
        rsp_t        r;
        nb = 1 << sz;
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 20 cycles");
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        e = {1'b0, a} + 65'(nb);
        r.err = e > 65'(MEM_BYTES);
        r.rdata = '0;
        if (r.err) begin
            r.cyc = acc;
        end else begin
            if ((a & 64'(nb - 1)) == 64'd0) begin
                bq.push_back('{a, 4'(nb), w, wd});
                r.cyc = acc + 1;
            end else begin
                for (int k = 0; k < nb; k++) bq.push_back('{a + 64'(k), 4'd1, w, (wd >> (8 * k)) & 64'hFF});
                r.cyc = acc + nb;
            end
            if (w) begin
                for (int k = 0; k < nb; k++)
                    if (commit < 0 || k < commit) ref_mem[10'(a + 64'(k))] = 8'(wd >> (8 * k));
            end else begin
                v = '0;
                for (int k = 0; k < nb; k++) v = v | (64'(ref_mem[10'(a + 64'(k))]) << (8 * k));
                r.rdata = extend(v, nb, sg);
            end
        end
        rq.push_back(r);
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", rq.size());
            rq.delete();
            bq.delete();
        end
    endtask

    initial begin
        #(5000 * 30000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          a1;
        int          a2;
        int          e0;
        int          r;
        logic [1:0]  sz;
        logic [63:0] a;
        logic [63:0] wd;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i * 7 + 3);
        @(negedge clk);
        mem_init = 1'b1;
        @(negedge clk);
        check("reset_req_ready", 64'(req_ready), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_error", 64'(rsp_error), 64'd0);
        check("reset_rsp_rdata", rsp_rdata, 64'd0);
        check("reset_enables", {62'd0, mem_write_enable, mem_read_enable}, 64'd0);
        check("reset_mem_addr", mem_address, 64'd0);
        check("reset_mem_wdata", mem_write_data, 64'd0);
        check("reset_xfer_size", 64'(mem_xfer_size), 64'd8);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, -1, 1'b0, acc);
        drain();
        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, -1, 1'b0, acc);
        issue(1'b0, 2'd0, 1'b1, 64'h10, 64'h0, -1, 1'b0, acc);
        issue(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, -1, 1'b0, acc);
        issue(1'b0, 2'd1, 1'b1, 64'h16, 64'h0, -1, 1'b0, acc);
        issue(1'b0, 2'd2, 1'b0, 64'h13, 64'h0, -1, 1'b0, acc);
        drain();

        e0 = en_cnt;
        issue(1'b1, 2'd3, 1'b0, 64'h3FC, 64'hDEADBEEFCAFEF00D, -1, 1'b0, acc);
        issue(1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5A, -1, 1'b0, acc);
        drain();
        check("oob_no_enable", 64'(en_cnt), 64'(e0));
        for (int i = 16'h3FC; i < 16'h400; i++) check("oob_mem_unchanged", 64'(mem_arr[i]), 64'(ref_mem[i]));

        issue(1'b1, 2'd2, 1'b0, 64'h21, 64'hAABBCCDD, 2, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_we_drop", 64'(mem_write_enable), 64'd0);
        check("abort_re_drop", 64'(mem_read_enable), 64'd0);
        check("abort_no_rsp", 64'(rsp_valid), 64'd0);
        bq.delete();
        rq.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        for (int i = 16'h20; i < 16'h26; i++) check("abort_mem_bytes", 64'(mem_arr[i]), 64'(ref_mem[i]));
        check("abort_byte_21", 64'(mem_arr[16'h21]), 64'hDD);

        issue(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, -1, 1'b1, a1);
        check("b2b_ready_low", 64'(req_ready), 64'd0);
        issue(1'b0, 2'd1, 1'b1, 64'h16, 64'h0, -1, 1'b0, a2);
        check("b2b_accept_gap", 64'(a2 - a1), 64'd3);
        drain();

        for (int t = 0; t < 200; t++) begin
            sz = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 15));
            if (r == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else if (r == 1) a = 64'(MEM_BYTES - int'($urandom_range(0, 8)));
            else a = 64'($urandom_range(0, MEM_BYTES - 1));
            wd = {$urandom, $urandom};
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd, -1, 1'b0, acc);
        end
        drain();
        for (int i = 0; i < MEM_BYTES; i += 37) check("final_mem", 64'(mem_arr[i]), 64'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
